// File: rtl/sort_pkg.sv
// Shared constants for the sort network blocks (sort_net, merge_2, sort_unpack).
package sort_pkg;

   localparam int unsigned DATA_W_DEF   = 8;
   localparam int unsigned LOG_SIZE_DEF = 4;
   localparam int unsigned IDX_W        = LOG_SIZE_DEF;

   // Occupancy of the two-slot output buffer: 0, 1 or 2 vectors.
   localparam int unsigned CNT_W = 2;
   typedef logic [CNT_W-1:0] cnt_t;
   localparam cnt_t CNT_FULL = 2'd2;

endpackage

// File: rtl/sort_unpack_if.sv
// Vector-in / element-out stream bus of sort_unpack; slave is the unpacker, master the environment.
interface sort_unpack_if
   import sort_pkg::*;
#(
   parameter int unsigned DATA_W   = DATA_W_DEF,
   parameter int unsigned LOG_SIZE = IDX_W
);
   localparam int unsigned SIZE = 1 << LOG_SIZE;

   logic                     i_valid;
   logic                     o_ready;
   logic [DATA_W*SIZE-1:0]   i_din;
   logic                     i_flush;
   logic                     o_valid;
   logic                     i_ready;
   logic [DATA_W-1:0]        o_dout;
   logic [LOG_SIZE-1:0]      o_idx;
   logic                     o_last;

   modport slave (
      input  i_valid, i_din, i_flush, i_ready,
      output o_ready, o_valid, o_dout, o_idx, o_last
   );

   modport master (
      output i_valid, i_din, i_flush, i_ready,
      input  o_ready, o_valid, o_dout, o_idx, o_last
   );

endinterface

// File: rtl/sort_unpack_slot.sv
// One sorted-vector holding register with write enable and element-select read.
module sort_unpack_slot
   import sort_pkg::*;
#(
   parameter  int unsigned DATA_W   = DATA_W_DEF,
   parameter  int unsigned LOG_SIZE = LOG_SIZE_DEF,
   localparam int unsigned SIZE     = 1 << LOG_SIZE
) (
   input  logic                   clk,
   input  logic                   we_i,
   input  logic [DATA_W*SIZE-1:0] din_i,
   input  logic [LOG_SIZE-1:0]    sel_i,
   output logic [DATA_W-1:0]      elem_c_o
);

   logic [DATA_W-1:0] elem_q [SIZE];

   // Data storage only; contents are don't-care until written, so no reset.
   always_ff @(posedge clk) begin
      if (we_i) begin
         for (int unsigned k = 0; k < SIZE; k++) begin
            elem_q[k] <= din_i[k*DATA_W +: DATA_W];
         end
      end
   end

   assign elem_c_o = elem_q[sel_i];

endmodule

// File: rtl/sort_unpack.sv
// Sort network output stage: buffers two sorted vectors (ping-pong) and streams them one element per beat.
module sort_unpack
   import sort_pkg::*;
#(
   parameter  int unsigned DATA_W   = DATA_W_DEF,
   parameter  int unsigned LOG_SIZE = LOG_SIZE_DEF,
   localparam int unsigned SIZE     = 1 << LOG_SIZE
) (
   input  logic         clk,
   input  logic         rst_n,
   sort_unpack_if.slave bus
);

   localparam logic [LOG_SIZE-1:0] IDX_MAX = LOG_SIZE'(SIZE - 1);

   cnt_t                count_q, count_d;
   logic                wr_ptr_q, wr_ptr_d;
   logic                rd_ptr_q, rd_ptr_d;
   logic [LOG_SIZE-1:0] idx_q, idx_d;
   logic                ready_q, ready_d;
   logic                valid_q, valid_d;
   logic                last_q, last_d;

   logic                accept_c, pop_c, retire_c;
   logic                we0_c, we1_c;
   logic [DATA_W-1:0]   elem0_c, elem1_c;

   assign accept_c = bus.i_valid && ready_q;
   assign pop_c    = valid_q && bus.i_ready;
   assign retire_c = pop_c && (idx_q == IDX_MAX);

   // A flushed accept must not disturb the slot being drained either.
   assign we0_c = accept_c && !bus.i_flush && !wr_ptr_q;
   assign we1_c = accept_c && !bus.i_flush &&  wr_ptr_q;

   sort_unpack_slot #(.DATA_W(DATA_W), .LOG_SIZE(LOG_SIZE)) u_slot0 (
      .clk      (clk),
      .we_i     (we0_c),
      .din_i    (bus.i_din),
      .sel_i    (idx_q),
      .elem_c_o (elem0_c)
   );

   sort_unpack_slot #(.DATA_W(DATA_W), .LOG_SIZE(LOG_SIZE)) u_slot1 (
      .clk      (clk),
      .we_i     (we1_c),
      .din_i    (bus.i_din),
      .sel_i    (idx_q),
      .elem_c_o (elem1_c)
   );

   always_comb begin
      count_d  = count_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      idx_d    = idx_q;

      if (bus.i_flush) begin
         count_d  = '0;
         wr_ptr_d = 1'b0;
         rd_ptr_d = 1'b0;
         idx_d    = '0;
      end else begin
         if (accept_c) begin
            wr_ptr_d = !wr_ptr_q;
         end
         if (pop_c) begin
            if (retire_c) begin
               idx_d    = '0;
               rd_ptr_d = !rd_ptr_q;
            end else begin
               idx_d = idx_q + LOG_SIZE'(1);
            end
         end
         if (accept_c && !retire_c) begin
            count_d = count_q + cnt_t'(1);
         end else if (!accept_c && retire_c) begin
            count_d = count_q - cnt_t'(1);
         end
      end

      // Handshake flags are precomputed from next state so they leave flops directly.
      ready_d = (count_d != CNT_FULL);
      valid_d = (count_d != '0);
      last_d  = valid_d && (idx_d == IDX_MAX);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q  <= '0;
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         idx_q    <= '0;
         ready_q  <= 1'b1;
         valid_q  <= 1'b0;
         last_q   <= 1'b0;
      end else begin
         count_q  <= count_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         idx_q    <= idx_d;
         ready_q  <= ready_d;
         valid_q  <= valid_d;
         last_q   <= last_d;
      end
   end

   assign bus.o_ready = ready_q;
   assign bus.o_valid = valid_q;
   assign bus.o_idx   = idx_q;
   assign bus.o_last  = last_q;
   assign bus.o_dout  = rd_ptr_q ? elem1_c : elem0_c;

endmodule
